acia_rx_frame: RTL and testbench

Receive framing stage that sits directly downstream of the serial ULA and consumes its `RxC`/`RxD`/`DCD` outputs. It recovers asynchronous character frames (start, 7/8 data bits, optional parity, stop) from either the RS423 line or the recovered cassette clock and data. It holds one received byte with ACIA-style status flags for the 6502 side. All logic runs on the ULA fast clock; `RxC` is treated as a data signal and edge-detected, never used as a clock.

---
 rtl/acia_rx_frame.sv | 213 +++++++++++++++++++++
 tb/tb_acia_rx_frame.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acia_rx_frame.sv
// ACIA receive framing stage: RxC edge-detected ticks drive a start/data/parity/stop FSM into a one-byte holding register.
// Define ACIA_RX_DCD_EN to enable carrier-detect supervision (dcd_lost, frame abort on DCD).
module acia_rx_frame #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxc,
  input  logic       rxd,
  input  logic       dcd,
  input  logic [1:0] cfg_div,
  input  logic       cfg_bits7,
  input  logic [1:0] cfg_parity,
  input  logic       rd_data,
  output logic [7:0] rx_data,
  output logic       rdrf,
  output logic       ovrn,
  output logic       fe,
  output logic       pe,
  output logic       dcd_lost,
  output logic       irq
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_rxc_sync;
  logic [SYNC_STAGES-1:0] r_rxd_sync;
  logic                   r_rxc_d;
  logic [5:0]             r_tick_cnt;
  logic [2:0]             r_bit_cnt;
  logic [1:0]             r_div;
  logic                   r_bits7;
  logic [1:0]             r_parity;
  logic [7:0]             r_shift;
  logic                   r_par;
  logic                   r_pe_pending;
  logic                   r_brk;
  logic                   w_rxc_s;
  logic                   w_rxd_s;
  logic                   w_tick;
  logic                   w_abort;
  logic                   w_sample;
  logic                   w_load;
  logic [5:0]             w_period_m1;
  logic [5:0]             w_half_m1;

  // NOTE: sequential state is written with non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxc_sync <= '1;
      r_rxd_sync <= '1;
      r_rxc_d    <= 1'b1;
    end else begin
      r_rxc_sync <= {r_rxc_sync[SYNC_STAGES-2:0], rxc};
      r_rxd_sync <= {r_rxd_sync[SYNC_STAGES-2:0], rxd};
      r_rxc_d    <= w_rxc_s;
    end
  end

  assign w_rxc_s = r_rxc_sync[SYNC_STAGES-1];
  assign w_rxd_s = r_rxd_sync[SYNC_STAGES-1];
  assign w_tick  = w_rxc_s & ~r_rxc_d;

`ifdef ACIA_RX_DCD_EN
  logic [SYNC_STAGES-1:0] r_dcd_sync;
  logic                   r_dcd_d;
  logic                   w_dcd_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dcd_sync <= '0;
      r_dcd_d    <= 1'b0;
      dcd_lost   <= 1'b0;
    end else begin
      r_dcd_sync <= {r_dcd_sync[SYNC_STAGES-2:0], dcd};
      r_dcd_d    <= w_dcd_s;
      if (w_dcd_s && !r_dcd_d)
        dcd_lost <= 1'b1;
      else if (rd_data && !w_dcd_s)
        dcd_lost <= 1'b0;
    end
  end

  assign w_dcd_s = r_dcd_sync[SYNC_STAGES-1];
  assign w_abort = w_dcd_s;
`else
  logic w_unused_dcd;
  assign w_unused_dcd = dcd;
  assign dcd_lost     = 1'b0;
  assign w_abort      = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_period_m1 = 6'd0;
    w_half_m1   = 6'd0;
    case (r_div)
      2'b01:   begin w_period_m1 = 6'd15; w_half_m1 = 6'd7;  end
      2'b10:   begin w_period_m1 = 6'd63; w_half_m1 = 6'd31; end
      default: ;
    endcase
  end

  assign w_sample = w_tick && (r_tick_cnt == w_period_m1);
  assign w_load   = (r_state == S_STOP) && w_sample && !w_abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_tick_cnt   <= 6'd0;
      r_bit_cnt    <= 3'd0;
      r_div        <= 2'b00;
      r_bits7      <= 1'b0;
      r_parity     <= 2'b00;
      r_shift      <= 8'h00;
      r_par        <= 1'b0;
      r_pe_pending <= 1'b0;
      r_brk        <= 1'b0;
      rx_data      <= 8'h00;
      rdrf         <= 1'b0;
      ovrn         <= 1'b0;
      fe           <= 1'b0;
      pe           <= 1'b0;
    end else begin
      if (w_abort) begin
        r_state    <= S_IDLE;
        r_tick_cnt <= 6'd0;
        r_bit_cnt  <= 3'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_tick && cfg_div != 2'b11) begin
              if (w_rxd_s) begin
                r_brk <= 1'b0;
              end else if (!r_brk) begin
                r_div        <= cfg_div;
                r_bits7      <= cfg_bits7;
                r_parity     <= cfg_parity;
                r_tick_cnt   <= 6'd0;
                r_bit_cnt    <= 3'd0;
                r_shift      <= 8'h00;
                r_par        <= 1'b0;
                r_pe_pending <= 1'b0;
                r_state      <= (cfg_div == 2'b00) ? S_DATA : S_START;
              end
            end
          end
          S_START: begin
            if (w_tick) begin
              if (r_tick_cnt == w_half_m1) begin
                r_tick_cnt <= 6'd0;
                r_state    <= w_rxd_s ? S_IDLE : S_DATA;
              end else begin
                r_tick_cnt <= r_tick_cnt + 6'd1;
              end
            end
          end
          S_DATA: begin
            if (w_sample) begin
              r_tick_cnt <= 6'd0;
              r_shift    <= {w_rxd_s, r_shift[7:1]};
              r_par      <= r_par ^ w_rxd_s;
              if (r_bit_cnt == (r_bits7 ? 3'd6 : 3'd7)) begin
                r_bit_cnt <= 3'd0;
                r_state   <= (r_parity == 2'b01 || r_parity == 2'b10) ? S_PARITY : S_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end else if (w_tick) begin
              r_tick_cnt <= r_tick_cnt + 6'd1;
            end
          end
          S_PARITY: begin
            if (w_sample) begin
              r_tick_cnt   <= 6'd0;
              r_pe_pending <= (r_parity == 2'b01) ? (r_par ^ w_rxd_s) : ~(r_par ^ w_rxd_s);
              r_state      <= S_STOP;
            end else if (w_tick) begin
              r_tick_cnt <= r_tick_cnt + 6'd1;
            end
          end
          S_STOP: begin
            if (w_sample) begin
              r_tick_cnt <= 6'd0;
              r_state    <= S_IDLE;
              if (!w_rxd_s) r_brk <= 1'b1;
            end else if (w_tick) begin
              r_tick_cnt <= r_tick_cnt + 6'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end

      // A completed frame only lands when the holding register is free or being read this cycle.
      if (w_load && (!rdrf || rd_data)) begin
        rx_data <= r_bits7 ? {1'b0, r_shift[7:1]} : r_shift;
        rdrf    <= 1'b1;
        fe      <= ~w_rxd_s;
        pe      <= r_pe_pending;
      end else if (w_load) begin
        ovrn <= 1'b1;
      end else if (rd_data) begin
        rdrf <= 1'b0;
        ovrn <= 1'b0;
      end
    end
  end

  assign irq = rdrf | ovrn | dcd_lost;

endmodule

// File: tb/tb_acia_rx_frame.sv
// Bench for acia_rx_frame: a frame-level model of the holding register and flags, compared every cycle,
// plus literal expectations after each directed scenario.
module tb_acia_rx_frame;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxc;
  logic       rxd;
  logic       dcd;
  logic [1:0] cfg_div;
  logic       cfg_bits7;
  logic [1:0] cfg_parity;
  logic       rd_data;
  logic [7:0] rx_data;
  logic       rdrf;
  logic       ovrn;
  logic       fe;
  logic       pe;
  logic       dcd_lost;
  logic       irq;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  logic [7:0] m_data;
  logic       m_rdrf;
  logic       m_ovrn;
  logic       m_fe;
  logic       m_pe;
  logic       m_dcd_lost;

  acia_rx_frame #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .rxc        (rxc),
    .rxd        (rxd),
    .dcd        (dcd),
    .cfg_div    (cfg_div),
    .cfg_bits7  (cfg_bits7),
    .cfg_parity (cfg_parity),
    .rd_data    (rd_data),
    .rx_data    (rx_data),
    .rdrf       (rdrf),
    .ovrn       (ovrn),
    .fe         (fe),
    .pe         (pe),
    .dcd_lost   (dcd_lost),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data     = 8'h00;
    m_rdrf     = 1'b0;
    m_ovrn     = 1'b0;
    m_fe       = 1'b0;
    m_pe       = 1'b0;
    m_dcd_lost = 1'b0;
  endtask

  task automatic do_read();
    rd_data = 1'b1;
    tick(1);
    rd_data = 1'b0;
    m_rdrf  = 1'b0;
    m_ovrn  = 1'b0;
    if (dcd == 1'b0) m_dcd_lost = 1'b0;
  endtask

  // Drives one frame as rxc edges (n edges per bit, rxd changed only at bit boundaries).
  // brk: extra low bit periods after the stop bit; dcd_edge/rst_edge: edge index to raise dcd / pulse reset (-1 = never).
  task automatic send_frame(input logic [1:0] div, input logic b7, input logic [1:0] par,
                            input logic [7:0] data, input logic par_flip, input logic stop_bit,
                            input int brk, input int dcd_edge, input int rst_edge);
    logic [31:0] v;
    int          n, nd, idx, stop_idx, stop_edge, nbits, ones;
    logic        pbit, par_en, pe_exp, will_load;
    n      = (div == 2'b01) ? 16 : (div == 2'b10) ? 64 : 1;
    nd     = b7 ? 7 : 8;
    par_en = (par == 2'b01) || (par == 2'b10);
    ones   = $countones(data & (b7 ? 8'h7f : 8'hff));
    pbit   = ((par == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0)) ^ par_flip;
    pe_exp = par_en ? ((par == 2'b01) ? ((ones + pbit) % 2 != 0) : ((ones + pbit) % 2 != 1)) : 1'b0;
    v      = '1;
    v[0]   = 1'b0;
    for (int i = 0; i < nd; i++) v[1+i] = data[i];
    idx = 1 + nd;
    if (par_en) begin
      v[idx] = pbit;
      idx++;
    end
    stop_idx    = idx;
    v[stop_idx] = stop_bit;
    for (int k = 1; k <= brk; k++) v[stop_idx+k] = 1'b0;
    nbits     = stop_idx + 1 + brk + ((brk > 0) ? 12 : 0);
    stop_edge = stop_idx * n + n / 2;
    will_load = (div != 2'b11);
`ifdef ACIA_RX_DCD_EN
    if (dcd_edge >= 0 && dcd_edge < stop_edge) will_load = 1'b0;
`endif
    cfg_div    = div;
    cfg_bits7  = b7;
    cfg_parity = par;
    for (int e = 0; e < nbits * n; e++) begin
      rxd = v[e/n];
      if (e == rst_edge) begin
        mon_en = 1'b0;
        tick(1);
        reset = 1'b1;
        #1;
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rdrf", rdrf, 0);
        check("rst_ovrn", ovrn, 0);
        check("rst_fe", fe, 0);
        check("rst_pe", pe, 0);
        check("rst_dcd_lost", dcd_lost, 0);
        check("rst_irq", irq, 0);
        rxc = 1'b1;
        rxd = 1'b1;
        tick(1);
        reset = 1'b0;
        model_reset();
        tick(2);
        mon_en = 1'b1;
        return;
      end
      if (e == dcd_edge) begin
        dcd    = 1'b1;
        mon_en = 1'b0;
      end
      rxc = 1'b0;
      tick(2);
      if (e == stop_edge) mon_en = 1'b0;
      rxc = 1'b1;
      tick(2);
      if (e == dcd_edge) begin
        tick(3);
`ifdef ACIA_RX_DCD_EN
        m_dcd_lost = 1'b1;
`endif
        mon_en = 1'b1;
      end
      if (e == stop_edge) begin
        tick(3);
        if (will_load) begin
          if (!m_rdrf) begin
            m_data = b7 ? {1'b0, data[6:0]} : data;
            m_rdrf = 1'b1;
            m_fe   = ~stop_bit;
            m_pe   = pe_exp;
          end else begin
            m_ovrn = 1'b1;
          end
        end
        mon_en = 1'b1;
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    rxc        = 1'b1;
    rxd        = 1'b1;
    dcd        = 1'b0;
    rd_data    = 1'b0;
    cfg_div    = 2'b00;
    cfg_bits7  = 1'b0;
    cfg_parity = 2'b00;
    model_reset();

    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          n_checks++;
          if ({rx_data, rdrf, ovrn, fe, pe, dcd_lost, irq} !==
              {m_data, m_rdrf, m_ovrn, m_fe, m_pe, m_dcd_lost, m_rdrf | m_ovrn | m_dcd_lost}) begin
            n_fail++;
            $display("FAIL mon t=%0t got data=%h rdrf=%b ovrn=%b fe=%b pe=%b dcd_lost=%b irq=%b exp data=%h rdrf=%b ovrn=%b fe=%b pe=%b dcd_lost=%b irq=%b",
                     $time, rx_data, rdrf, ovrn, fe, pe, dcd_lost, irq,
                     m_data, m_rdrf, m_ovrn, m_fe, m_pe, m_dcd_lost, m_rdrf | m_ovrn | m_dcd_lost);
          end
        end
      end
    join_none

    tick(3);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rdrf", rdrf, 0);
    check("reset_irq", irq, 0);
    check("reset_fe", fe, 0);
    reset = 1'b0;
    tick(2);
    mon_en = 1'b1;

    // /1, 8N1, 0x55
    send_frame(2'b00, 1'b0, 2'b00, 8'h55, 1'b0, 1'b1, 0, -1, -1);
    check("t1_rx_data", rx_data, 8'h55);
    check("t1_rdrf", rdrf, 1);
    check("t1_irq", irq, 1);
    check("t1_fe", fe, 0);
    check("t1_pe", pe, 0);
    do_read();
    check("t1_rdrf_after_rd", rdrf, 0);

    // /16, 7E1, 0x41 with the parity bit inverted
    send_frame(2'b01, 1'b1, 2'b01, 8'h41, 1'b1, 1'b1, 0, -1, -1);
    check("t2_rx_data", rx_data, 8'h41);
    check("t2_pe", pe, 1);
    check("t2_fe", fe, 0);
    for (int e = 0; e < 32; e++) begin
      rxd = (e < 2) ? 1'b0 : 1'b1;
      rxc = 1'b0;
      tick(2);
      rxc = 1'b1;
      tick(2);
    end
    check("t2_glitch_ovrn", ovrn, 0);
    check("t2_glitch_data", rx_data, 8'h41);
    do_read();

    // /16, 8O1, 0xC3 with correct parity
    send_frame(2'b01, 1'b0, 2'b10, 8'hC3, 1'b0, 1'b1, 0, -1, -1);
    check("t2b_rx_data", rx_data, 8'hC3);
    check("t2b_pe", pe, 0);
    do_read();

    // /1, back-to-back 0x12 and 0x34 without a read
    send_frame(2'b00, 1'b0, 2'b00, 8'h12, 1'b0, 1'b1, 0, -1, -1);
    send_frame(2'b00, 1'b0, 2'b00, 8'h34, 1'b0, 1'b1, 0, -1, -1);
    check("t3_rx_data", rx_data, 8'h12);
    check("t3_ovrn", ovrn, 1);
    check("t3_rdrf", rdrf, 1);
    do_read();
    do_read();
    check("t3_ovrn_after_rd", ovrn, 0);
    check("t3_rdrf_after_rd", rdrf, 0);

    // /64, 8N1 break: stop bit low for three bit periods, then line idles high
    send_frame(2'b10, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2, -1, -1);
    check("t4_fe", fe, 1);
    check("t4_rdrf", rdrf, 1);
    check("t4_ovrn", ovrn, 0);
    check("t4_rx_data", rx_data, 8'h00);
    do_read();
    send_frame(2'b01, 1'b0, 2'b00, 8'h3C, 1'b0, 1'b1, 0, -1, -1);
    check("t4_resume_data", rx_data, 8'h3C);
    check("t4_resume_fe", fe, 0);
    do_read();

    // receiver held idle
    send_frame(2'b11, 1'b0, 2'b00, 8'h0F, 1'b0, 1'b1, 0, -1, -1);
    check("t5_idle_rdrf", rdrf, 0);

    // carrier raised at data bit 3
    send_frame(2'b00, 1'b0, 2'b00, 8'h96, 1'b0, 1'b1, 0, 4, -1);
`ifdef ACIA_RX_DCD_EN
    check("t6_rdrf", rdrf, 0);
    check("t6_dcd_lost", dcd_lost, 1);
    check("t6_irq", irq, 1);
    do_read();
    check("t6_dcd_lost_held", dcd_lost, 1);
    dcd = 1'b0;
    tick(6);
    do_read();
    check("t6_dcd_lost_clr", dcd_lost, 0);
    check("t6_irq_clr", irq, 0);
`else
    check("t6_rx_data", rx_data, 8'h96);
    check("t6_dcd_lost", dcd_lost, 0);
    dcd = 1'b0;
    tick(6);
    do_read();
`endif

    // reset mid-DATA, then a clean frame
    send_frame(2'b00, 1'b0, 2'b00, 8'h5A, 1'b0, 1'b1, 0, -1, -1);
    check("t7_pre_rdrf", rdrf, 1);
    send_frame(2'b00, 1'b0, 2'b00, 8'hFF, 1'b0, 1'b1, 0, -1, 5);
    send_frame(2'b00, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b1, 0, -1, -1);
    check("t7_rx_data", rx_data, 8'hA5);
    check("t7_rdrf", rdrf, 1);
    check("t7_fe", fe, 0);
    do_read();
    tick(4);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
